// File: rtl/mult_arbiter_if.sv
// Bundle between mult_arbiter, its two requesters, its response consumer and the shared multiplier.
// The master modport is the environment side; the slave modport is the arbiter.
interface mult_arbiter_if #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
);
    logic               req0_valid;
    logic               req0_ready;
    logic [A_WIDTH-1:0] req0_a;
    logic [B_WIDTH-1:0] req0_b;
    logic               req0_tc;

    logic               req1_valid;
    logic               req1_ready;
    logic [A_WIDTH-1:0] req1_a;
    logic [B_WIDTH-1:0] req1_b;
    logic               req1_tc;

    logic [A_WIDTH-1:0] mult_a;
    logic [B_WIDTH-1:0] mult_b;
    logic               mult_tc;
    logic [P_WIDTH-1:0] mult_product;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [P_WIDTH-1:0] rsp_product;

    logic               busy;
    logic [15:0]        done_cnt;

    modport master (
        output req0_valid, req0_a, req0_b, req0_tc,
        output req1_valid, req1_a, req1_b, req1_tc,
        output mult_product, rsp_ready,
        input  req0_ready, req1_ready,
        input  mult_a, mult_b, mult_tc,
        input  rsp_valid, rsp_id, rsp_product,
        input  busy, done_cnt
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tc,
        input  req1_valid, req1_a, req1_b, req1_tc,
        input  mult_product, rsp_ready,
        output req0_ready, req1_ready,
        output mult_a, mult_b, mult_tc,
        output rsp_valid, rsp_id, rsp_product,
        output busy, done_cnt
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier between two requesters; response 2 cycles after accept
// (3 with MULT_ARB_PIPE_EN), held until rsp_ready; requests are only accepted in IDLE, so a stalled response blocks both requesters.
module mult_arbiter #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    mult_arbiter_if.slave bus
);

`ifdef MULT_ARB_PIPE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;
`endif

    state_e             state_q, state_d;
    logic               arm_q;
    logic               last_grant_q, last_grant_d;
    logic [A_WIDTH-1:0] a_q, a_d;
    logic [B_WIDTH-1:0] b_q, b_d;
    logic               tc_q, tc_d;
    logic               rsp_id_q, rsp_id_d;
    logic [P_WIDTH-1:0] rsp_product_q, rsp_product_d;
    logic [15:0]        done_cnt_q, done_cnt_d;
`ifdef MULT_ARB_PIPE_EN
    logic [P_WIDTH-1:0] pipe_q, pipe_d;
`endif

    logic accept;
    logic gnt_id;

    // arm_q drops asynchronously with rst_n, which keeps both readies low during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            arm_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            a_q           <= '0;
            b_q           <= '0;
            tc_q          <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_product_q <= '0;
            done_cnt_q    <= '0;
`ifdef MULT_ARB_PIPE_EN
            pipe_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            arm_q         <= 1'b1;
            last_grant_q  <= last_grant_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tc_q          <= tc_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            done_cnt_q    <= done_cnt_d;
`ifdef MULT_ARB_PIPE_EN
            pipe_q        <= pipe_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        a_d           = a_q;
        b_d           = b_q;
        tc_d          = tc_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        done_cnt_d    = done_cnt_q;
`ifdef MULT_ARB_PIPE_EN
        pipe_d        = pipe_q;
`endif
        accept        = 1'b0;
        // On a tie the requester that did not win last time goes next
        gnt_id        = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

        case (state_q)
            ST_IDLE: begin
                if (arm_q && (bus.req0_valid || bus.req1_valid)) begin
                    accept       = 1'b1;
                    state_d      = ST_MUL;
                    last_grant_d = gnt_id;
                    rsp_id_d     = gnt_id;
                    a_d          = gnt_id ? bus.req1_a  : bus.req0_a;
                    b_d          = gnt_id ? bus.req1_b  : bus.req0_b;
                    tc_d         = gnt_id ? bus.req1_tc : bus.req0_tc;
                end
            end
            ST_MUL: begin
`ifdef MULT_ARB_PIPE_EN
                pipe_d        = bus.mult_product;
                state_d       = ST_WAIT;
`else
                rsp_product_d = bus.mult_product;
                state_d       = ST_RESP;
`endif
            end
`ifdef MULT_ARB_PIPE_EN
            ST_WAIT: begin
                rsp_product_d = pipe_q;
                state_d       = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d    = ST_IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req0_ready  = accept & ~gnt_id;
    assign bus.req1_ready  = accept &  gnt_id;

    // Operand registers only change on accept, so the multiplier inputs hold between operations
    assign bus.mult_a      = a_q;
    assign bus.mult_b      = b_q;
    assign bus.mult_tc     = tc_q;

    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter driving it through its interface with a behavioural shared multiplier.
module tb_mult_arbiter;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = 16;
`ifdef MULT_ARB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_arbiter_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

    mult_arbiter #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared combinational multiplier outside the arbiter
    logic signed [PW-1:0] sprod;
    assign sprod = $signed(bus.mult_a) * $signed(bus.mult_b);
    assign bus.mult_product = bus.mult_tc ? sprod
                            : ({{BW{1'b0}}, bus.mult_a} * {{AW{1'b0}}, bus.mult_b});

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Issues one operation from IDLE with rsp_ready high and reports what came back
    task automatic run_op(input logic id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                          input logic tc, output int lat, output logic [PW-1:0] prod,
                          output logic rid, output logic rdy, output logic busy1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_tc = tc;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_tc = tc;
        end
        @(negedge clk);
        rdy = id ? bus.req1_ready : bus.req0_ready;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat   = -1;
        prod  = 'x;
        rid   = 1'bx;
        busy1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = bus.busy;
            if (bus.rsp_valid) begin
                lat  = k;
                prod = bus.rsp_product;
                rid  = bus.rsp_id;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34; bus.req0_tc = 1'b1;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tc = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.req0_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
        checks++; if (bus.rsp_product !== 16'h0000) begin errors++; $display("FAIL reset_rsp_product got %h want 0000", bus.rsp_product); end
        checks++; if (bus.done_cnt !== 16'h0000) begin errors++; $display("FAIL reset_done_cnt got %h want 0000", bus.done_cnt); end
        checks++; if ({bus.mult_a, bus.mult_b, bus.mult_tc} !== 17'h0) begin errors++; $display("FAIL reset_mult got %h/%h/%b want 0/0/0", bus.mult_a, bus.mult_b, bus.mult_tc); end
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_signed_basic;
        int lat; logic [PW-1:0] prod; logic rid, rdy, b1;
        run_op(1'b0, 8'hFD, 8'h05, 1'b1, lat, prod, rid, rdy, b1);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", rdy); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL basic_id got %b want 0", rid); end
        checks++; if (prod !== 16'hFFF1) begin errors++; $display("FAIL basic_product got %h want fff1", prod); end
        checks++; if (bus.done_cnt !== 16'd1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", bus.done_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
        checks++; if (bus.mult_a !== 8'hFD || bus.mult_tc !== 1'b1) begin errors++; $display("FAIL basic_mult_hold got %h/%b want fd/1", bus.mult_a, bus.mult_tc); end
    endtask

    task automatic test_mult_modes;
        int lat; logic [PW-1:0] prod; logic rid, rdy, b1;
        run_op(1'b1, 8'hFF, 8'hFF, 1'b0, lat, prod, rid, rdy, b1);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL unsigned_ready got %b want 1", rdy); end
        checks++; if (rid !== 1'b1) begin errors++; $display("FAIL unsigned_id got %b want 1", rid); end
        checks++; if (prod !== 16'hFE01) begin errors++; $display("FAIL unsigned_product got %h want fe01", prod); end
        run_op(1'b1, 8'hFF, 8'hFF, 1'b1, lat, prod, rid, rdy, b1);
        checks++; if (prod !== 16'h0001) begin errors++; $display("FAIL signed_ff_product got %h want 0001", prod); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL signed_ff_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus.done_cnt !== 16'd3) begin errors++; $display("FAIL modes_done_cnt got %0d want 3", bus.done_cnt); end
    endtask

    task automatic test_pipe_boundary;
        int lat; logic [PW-1:0] prod; logic rid, rdy, b1;
        run_op(1'b0, 8'h80, 8'h80, 1'b1, lat, prod, rid, rdy, b1);
        checks++; if (prod !== 16'h4000) begin errors++; $display("FAIL minsq_product got %h want 4000", prod); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL minsq_latency got %0d want %0d", lat, LAT); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL minsq_busy_t1 got %b want 1", b1); end
    endtask

    task automatic test_round_robin;
        int g[4]; int t[4]; int n = 0; int both = 0; int w = 0;
        for (int i = 0; i < 4; i++) begin g[i] = -1; t[i] = 0; end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd2; bus.req0_b = 8'd3; bus.req0_tc = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd4; bus.req1_b = 8'd5; bus.req1_tc = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) both++;
            if (bus.req0_ready || bus.req1_ready) begin
                g[n] = bus.req1_ready ? 1 : 0;
                t[n] = c;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        while (bus.busy && w < 10) begin @(posedge clk); #1; w++; end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_grant_count got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (g[i] != (i % 2)) begin errors++; $display("FAIL rr_grant%0d got %0d want %0d", i, g[i], i % 2); end
        end
        checks++; if (both != 0) begin errors++; $display("FAIL rr_dual_ready got %0d cycles want 0", both); end
        checks++; if (t[1] - t[0] != LAT + 1) begin errors++; $display("FAIL rr_spacing got %0d want %0d", t[1] - t[0], LAT + 1); end
        checks++; if (bus.busy !== 1'b0 || bus.done_cnt !== 16'd4) begin errors++; $display("FAIL rr_drain got busy %b cnt %0d want 0/4", bus.busy, bus.done_cnt); end
    endtask

    task automatic test_backpressure;
        int w = 0; logic [15:0] base;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd7; bus.req0_b = 8'd6; bus.req0_tc = 1'b0;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd9; bus.req1_b = 8'd9; bus.req1_tc = 1'b0;
        do begin @(negedge clk); w++; end while (!bus.rsp_valid && w < 10);
        base = bus.done_cnt;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 16'h002A || bus.rsp_id !== 1'b0)
            begin errors++; $display("FAIL bp_first got v%b %h id%b want v1 002a id0", bus.rsp_valid, bus.rsp_product, bus.rsp_id); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 16'h002A || bus.rsp_id !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d got v%b %h id%b want v1 002a id0", i, bus.rsp_valid, bus.rsp_product, bus.rsp_id); end
            checks++; if (bus.req1_ready !== 1'b0 || bus.done_cnt !== base)
                begin errors++; $display("FAIL bp_block%0d got rdy%b cnt%0d want rdy0 cnt%0d", i, bus.req1_ready, bus.done_cnt, base); end
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_handshake_valid got %b want 1", bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.done_cnt !== base + 16'd1) begin errors++; $display("FAIL bp_done_cnt got %0d want %0d", bus.done_cnt, base + 16'd1); end
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.mult_a !== 8'd7) begin errors++; $display("FAIL bp_no_capture got busy%b a%h want busy0 a07", bus.busy, bus.mult_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen = 0; int w = 0;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h02; bus.req0_tc = 1'b0;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        #2;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_in_mul got busy %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async got busy%b v%b want 0/0", bus.busy, bus.rsp_valid); end
        checks++; if (bus.done_cnt !== 16'd0 || bus.mult_a !== 8'h00 || bus.rsp_product !== 16'h0) begin errors++; $display("FAIL mid_regs got cnt%0d a%h p%h want 0/00/0000", bus.done_cnt, bus.mult_a, bus.rsp_product); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.rsp_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_response got %0d cycles valid want 0", seen); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd4; bus.req0_tc = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd5; bus.req1_b = 8'd6; bus.req1_tc = 1'b0;
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL mid_regrant got r0 %b r1 %b want 1/0", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        do begin @(negedge clk); w++; end while (!bus.rsp_valid && w < 10);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 16'd12 || bus.rsp_id !== 1'b0)
            begin errors++; $display("FAIL mid_after got v%b %h id%b want v1 000c id0", bus.rsp_valid, bus.rsp_product, bus.rsp_id); end
        @(negedge clk);
        checks++; if (bus.done_cnt !== 16'd1) begin errors++; $display("FAIL mid_done_cnt got %0d want 1", bus.done_cnt); end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_mult_modes();
        test_pipe_boundary();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
